// File: rtl/swi_reg_monitor.sv
// ============================================================================
// swi_reg_monitor
// ----------------------------------------------------------------------------
// Switch-driven register-file monitor. A two-bit command field on the
// switches selects IDLE / WRITE / STEP / CLEAR. Each command acts once per
// press: it is accepted only on the cycle the field leaves 00. The block
// keeps a small register file, a step counter, a saturating write counter,
// a shift register of written bytes and a free-running cycle counter, and
// exposes all of them for display.
//
// Ports
//   clk_2            in   1          sole clock, rising edge
//   reset            in   1          synchronous, active-high
//   SWI              in   NBITS      [NBITS-1:NBITS-2] command, [NBITS-3:0] data
//   LED              out  NBITS      {busy, write pointer padded/truncated}
//   SEG              out  NBITS      accepted-write count, saturating
//   lcd_registrador  out  NBITS x NREGS  register file contents
//   lcd_pc           out  NBITS      step counter
//   lcd_WriteData    out  NBITS      zero-extended data field (combinational)
//   lcd_Result       out  NBITS      last value written to the register file
//   lcd_RegWrite     out  1          one-cycle pulse after each accepted write
//   lcd_a            out  NBITS_LCD  history of written bytes, newest in LSBs
//   lcd_b            out  NBITS_LCD  free-running cycle counter
// ============================================================================
module swi_reg_monitor #(
    parameter int NBITS     = 8,   // datapath width, at least 4
    parameter int NREGS     = 32,  // register count, power of two 2..256
    parameter int NBITS_LCD = 64   // history/cycle width, multiple of NBITS
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic [NBITS-1:0]     SWI,
    output logic [NBITS-1:0]     LED,
    output logic [NBITS-1:0]     SEG,
    output logic [NBITS-1:0]     lcd_registrador [0:NREGS-1],
    output logic [NBITS-1:0]     lcd_pc,
    output logic [NBITS-1:0]     lcd_WriteData,
    output logic [NBITS-1:0]     lcd_Result,
    output logic                 lcd_RegWrite,
    output logic [NBITS_LCD-1:0] lcd_a,
    output logic [NBITS_LCD-1:0] lcd_b
);

    // Register index width.
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    // Command encodings.
    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    // FSM states.
    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_CLEARING = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]           r_state;
    logic [1:0]           r_cmd_prev;
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_clr_idx;
    logic [NBITS-1:0]     r_regs [0:NREGS-1];
    logic [NBITS-1:0]     r_pc;
    logic [NBITS-1:0]     r_result;
    logic [NBITS-1:0]     r_wr_count;
    logic                 r_regwrite;
    logic [NBITS_LCD-1:0] r_hist;
    logic [NBITS_LCD-1:0] r_cycles;

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    logic [1:0]           w_cmd;
    logic [NBITS-1:0]     w_data;
    logic                 w_accept_write;
    logic                 w_accept_step;
    logic                 w_accept_clear;
    logic                 w_clr_last;
    logic                 w_busy;
    logic [NBITS-2:0]     w_wptr_led;
    logic [NBITS_LCD-1:0] w_hist_next;

    assign w_cmd      = SWI[NBITS-1:NBITS-2];
    assign w_data     = {2'b00, SWI[NBITS-3:0]};
    assign w_busy     = (r_state == ST_CLEARING);
    assign w_clr_last = (r_clr_idx == AW'(NREGS - 1));

    // A command acts only on the edge where the field leaves 00, so holding
    // a switch produces one action. Nothing is accepted while clearing.
    // NOTE: every signal assigned in an always_comb gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        w_accept_write = 1'b0;
        w_accept_step  = 1'b0;
        w_accept_clear = 1'b0;
        if ((r_state == ST_IDLE) && (w_cmd != CMD_IDLE) && (r_cmd_prev == CMD_IDLE)) begin
            case (w_cmd)
                CMD_WRITE: w_accept_write = 1'b1;
                CMD_STEP:  w_accept_step  = 1'b1;
                CMD_CLEAR: w_accept_clear = 1'b1;
                default:   ;
            endcase
        end
    end

    // New byte enters the low end of the history; the oldest falls off.
    generate
        if (NBITS_LCD > NBITS) begin : g_hist_shift
            assign w_hist_next = {r_hist[NBITS_LCD-NBITS-1:0], w_data};
        end else begin : g_hist_single
            assign w_hist_next = w_data;
        end
    endgenerate

    // Write pointer shown on LED[NBITS-2:0], zero-padded or truncated.
    generate
        if (AW >= NBITS - 1) begin : g_led_trunc
            assign w_wptr_led = r_wptr[NBITS-2:0];
        end else begin : g_led_pad
            assign w_wptr_led = {{(NBITS - 1 - AW){1'b0}}, r_wptr};
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Control: FSM, command history, write pointer, clear sweep index
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            // All-ones here means a command held through reset release is
            // seen as already pressed and is not accepted.
            r_cmd_prev <= '1;
            r_wptr     <= '0;
            r_clr_idx  <= '0;
        end else begin
            // Tracked even while clearing, so a command held across the end
            // of the sweep is not accepted when the FSM returns to idle.
            r_cmd_prev <= w_cmd;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept_clear) begin
                        r_state   <= ST_CLEARING;
                        r_clr_idx <= '0;
                        r_wptr    <= '0;
                    end else if (w_accept_write) begin
                        r_wptr <= r_wptr + AW'(1);
                    end
                end
                ST_CLEARING: begin
                    r_clr_idx <= r_clr_idx + AW'(1);
                    if (w_clr_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Register file: one write port shared by WRITE and the clear sweep.
    // Writes are only accepted in idle, so the two never collide.
    // ------------------------------------------------------------------------
    // NOTE: the register file is reset because its contents are displayed
    // and must read as zero after reset; this forces flops, not RAM.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_accept_write) begin
            r_regs[r_wptr] <= w_data;
        end else if (r_state == ST_CLEARING) begin
            r_regs[r_clr_idx] <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath counters and display registers. None of these are touched by
    // the clear sweep.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_pc       <= '0;
            r_result   <= '0;
            r_wr_count <= '0;
            r_regwrite <= 1'b0;
            r_hist     <= '0;
            r_cycles   <= '0;
        end else begin
            r_cycles   <= r_cycles + NBITS_LCD'(1);
            r_regwrite <= w_accept_write;
            if (w_accept_write) begin
                r_result <= w_data;
                r_hist   <= w_hist_next;
                if (!(&r_wr_count)) begin
                    r_wr_count <= r_wr_count + NBITS'(1);
                end
            end
            if (w_accept_step) begin
                r_pc <= r_pc + NBITS'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign LED             = {w_busy, w_wptr_led};
    assign SEG             = r_wr_count;
    assign lcd_registrador = r_regs;
    assign lcd_pc          = r_pc;
    assign lcd_WriteData   = w_data;
    assign lcd_Result      = r_result;
    assign lcd_RegWrite    = r_regwrite;
    assign lcd_a           = r_hist;
    assign lcd_b           = r_cycles;

endmodule

// File: doc/swi_reg_monitor.md
SWI_REG_MONITOR -- requirements
Module: swi_reg_monitor

Interface
REQ-001 SHALL have parameter NBITS, default 8, datapath width of switches, LEDs, display bytes and registers (minimum 4).
REQ-002 SHALL have parameter NREGS, default 32, number of displayed registers (power of two, 2..256).
REQ-003 SHALL have parameter NBITS_LCD, default 64, width of lcd_a and lcd_b (integer multiple of NBITS).
REQ-004 SHALL have port clk_2  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port SWI  input  NBITS  command field SWI[NBITS-1:NBITS-2], data field SWI[NBITS-3:0].
REQ-007 SHALL have port LED  output  NBITS  {busy, write pointer, zero-padded/truncated to NBITS-1 bits}.
REQ-008 SHALL have port SEG  output  NBITS  total accepted-write count, saturating at all-ones.
REQ-009 SHALL have port lcd_registrador  output  NBITS x [0:NREGS-1]  register file contents.
REQ-010 SHALL have port lcd_pc  output  NBITS  step counter.
REQ-011 SHALL have port lcd_WriteData  output  NBITS  data field zero-extended, combinational from SWI.
REQ-012 SHALL have port lcd_Result  output  NBITS  last value written to the register file.
REQ-013 SHALL have port lcd_RegWrite  output  1  high for exactly one cycle after each accepted write.
REQ-014 SHALL have port lcd_a  output  NBITS_LCD  write history shift register.
REQ-015 SHALL have port lcd_b  output  NBITS_LCD  free-running cycle counter.

Function
REQ-016 SHALL decode commands: 00 IDLE, 01 WRITE, 10 STEP, 11 CLEAR.
REQ-017 SHALL register the command field each cycle as cmd_prev; a command is accepted only in a cycle where cmd != 00 and cmd_prev == 00 (one action per switch press).
REQ-018 SHALL on accepted WRITE: reg[wptr] <= zero-extended data; wptr <= wptr+1 modulo NREGS; lcd_Result <= data; lcd_a <= {lcd_a[NBITS_LCD-NBITS-1:0], data}; write count +1 (saturating); all visible the cycle after acceptance.
REQ-019 SHALL on accepted STEP: lcd_pc <= lcd_pc+1, wrapping from all-ones to 0.
REQ-020 SHALL on accepted CLEAR: enter state CLEARING, zero exactly one register per cycle from index 0 to NREGS-1 (NREGS cycles), set wptr to 0, then return to IDLE state; busy (LED[NBITS-1]) high throughout CLEARING.
REQ-021 SHALL ignore all commands while CLEARING, but keep updating cmd_prev, so a command held across CLEARING end is not accepted.
REQ-022 SHALL not alter lcd_pc, lcd_a, lcd_Result or the write count during CLEAR.
REQ-023 SHALL have FSM states IDLE and CLEARING only; IDLE -> CLEARING on accepted CLEAR; CLEARING -> IDLE in the cycle after index NREGS-1 is cleared.
REQ-024 SHALL increment lcd_b by 1 every non-reset cycle, wrapping modulo 2^NBITS_LCD.
REQ-025 SHALL keep lcd_RegWrite low except the single cycle after an accepted WRITE.

Reset
REQ-026 SHALL on reset drive all registers, lcd_pc, lcd_Result, lcd_a, lcd_b, write count, wptr to 0, lcd_RegWrite and busy to 0, state to IDLE.
REQ-027 SHALL on reset set cmd_prev to all-ones so a command held through reset release is not accepted.
REQ-028 SHALL let reset asserted mid-CLEARING abort the sweep and take precedence over any command in that cycle.

Verification
REQ-029 SHALL cover: reset, SWI=8'b01_000101 after an SWI=0 cycle -> next cycle reg[0]=5, lcd_Result=5, lcd_RegWrite=1 one cycle, SEG=1, LED=8'h01, lcd_a[7:0]=5.
REQ-030 SHALL cover: WRITE held 10 cycles -> exactly one write; 33 press/release WRITEs with NREGS=32 -> wptr wraps, reg[0] overwritten by 33rd value.
REQ-031 SHALL cover: 256 STEP presses -> lcd_pc returns to 0; 300 WRITE presses -> SEG saturates at 8'hFF.
REQ-032 SHALL cover: CLEAR press after writes -> busy high 32 cycles, reg[i] zero from cycle i+1, WRITE pressed mid-sweep ignored, lcd_pc and lcd_Result unchanged.
REQ-033 SHALL cover: SWI=8'b10_000000 held during reset release -> no STEP; reset at sweep cycle 10 -> all outputs 0, state IDLE next cycle.
